// File: rtl/mul_share_arb.sv
// Shares one 8x8 unsigned multiplier among NREQ round-robin requesters.
// Two-stage pipeline (operand reg, output reg) with per-requester 20-bit accumulators.
module mul_share_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    input  logic [NREQ-1:0]      req_acc,
    input  logic [NREQ-1:0]      acc_clr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [19:0]          rsp_data
);

    localparam int unsigned OPW = 8;
    localparam int unsigned PW  = 16;
    localparam int unsigned AW  = 20;

    logic            s1_v;
    logic [OPW-1:0]  s1_a;
    logic [OPW-1:0]  s1_b;
    logic [IDW-1:0]  s1_id;
    logic            s1_acc;
    logic [IDW-1:0]  rr_last;
    logic [AW-1:0]   accum [NREQ];

    logic            s2_free;
    logic            s1_adv;
    logic            s1_mv;
    logic            grant_v;
    logic [IDW-1:0]  grant_id;
    logic [OPW-1:0]  sel_a;
    logic [OPW-1:0]  sel_b;
    logic            sel_acc;
    logic            accept;
    logic [PW-1:0]   prod;
    logic [AW-1:0]   acc_cur;
    logic            clr_cur;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   s2_data_nxt;

    assign s2_free = !rsp_valid || rsp_ready;
    assign s1_adv  = !s1_v || s2_free;
    assign s1_mv   = s1_v && s2_free;

    // Round-robin search: indices above rr_last first, then wrap to 0..rr_last.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_v && req_valid[j] && (IDW'(j) > rr_last)) begin
                grant_v  = 1'b1;
                grant_id = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_v && req_valid[j] && (IDW'(j) <= rr_last)) begin
                grant_v  = 1'b1;
                grant_id = IDW'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_acc   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_id == IDW'(j)) begin
                req_ready[j] = rst_n && grant_v && s1_adv;
                sel_a        = req_a[j*OPW +: OPW];
                sel_b        = req_b[j*OPW +: OPW];
                sel_acc      = req_acc[j];
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    // Multiplier and accumulator datapath between S1 and S2; a same-edge clear zeroes the base.
    always_comb begin
        acc_cur = '0;
        clr_cur = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (s1_id == IDW'(j)) begin
                acc_cur = accum[j];
                clr_cur = acc_clr[j];
            end
        end
    end

    assign prod        = s1_a * s1_b;
    assign acc_sum     = (clr_cur ? '0 : acc_cur) + AW'(prod);
    assign s2_data_nxt = s1_acc ? acc_sum : AW'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= IDW'(NREQ - 1);
        end else if (accept) begin
            rr_last <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
            s1_acc <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= accept;
            if (accept) begin
                s1_a   <= sel_a;
                s1_b   <= sel_b;
                s1_id  <= grant_id;
                s1_acc <= sel_acc;
            end
        end
    end

    // Output register: valid drops on a bubble, id/data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (s1_mv) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id;
            rsp_data  <= s2_data_nxt;
        end else if (s2_free) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                accum[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (s1_mv && s1_acc && (s1_id == IDW'(i))) begin
                    accum[i] <= acc_sum;
                end else if (acc_clr[i]) begin
                    accum[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: single ops, accumulation, round-robin,
// backpressure, accumulator wrap/clear collision and mid-operation reset.
module tb_mul_share_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_acc;
    logic [1:0]  acc_clr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [19:0] rsp_data;

    int errors = 0;
    int checks = 0;

    mul_share_arb #(.NREQ(2), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_acc   (req_acc),
        .acc_clr   (acc_clr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int id, input int a, input int b, input bit acc);
        req_a[id*8 +: 8] = 8'(a);
        req_b[id*8 +: 8] = 8'(b);
        req_acc[id]      = acc;
    endtask

    // Present one request and hold it until accepted; returns just after the accept edge.
    task automatic issue(input int id, input int a, input int b, input bit acc);
        int n;
        set_op(id, a, b, acc);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        chk("issue_ready", 32'(req_ready[id]), 1);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int eid, input int edata);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(eid));
        chk({tag, "_data"}, 32'(rsp_data), 32'(edata));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_acc   = '0;
        acc_clr   = '0;
        rsp_ready = 1'b1;

        // Reset state, with requesters already valid.
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_data", 32'(rsp_data), 0);
        req_valid = 2'b00;
        #2;
        rst_n = 1'b1;
        tick();

        // Single op with latency check.
        issue(0, 12, 5, 1'b0);
        chk("lat_s1", 32'(rsp_valid), 0);
        tick();
        chk("lat_s2", 32'(rsp_valid), 1);
        chk("single_id", 32'(rsp_id), 0);
        chk("single_data", 32'(rsp_data), 60);
        tick();
        chk("single_bubble", 32'(rsp_valid), 0);

        issue(0, 255, 255, 1'b0);
        wait_rsp("max", 0, 65025);

        // Accumulate on requester 1, then clear.
        issue(1, 170, 85, 1'b1);
        wait_rsp("acc1", 1, 14450);
        issue(1, 240, 15, 1'b1);
        wait_rsp("acc2", 1, 18050);
        acc_clr = 2'b10;
        tick();
        acc_clr = 2'b00;
        issue(1, 12, 5, 1'b1);
        wait_rsp("acc_clr", 1, 60);

        // Round-robin, both continuously valid, full throughput.
        set_op(0, 3, 4, 1'b0);
        set_op(1, 5, 6, 1'b0);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 1 : 2);
            if (k >= 2) begin
                chk("rr_valid", 32'(rsp_valid), 1);
                chk("rr_id", 32'(rsp_id), k % 2);
                chk("rr_data", 32'(rsp_data), (k % 2 == 0) ? 12 : 30);
            end
            tick();
            #1;
        end
        req_valid = 2'b00;
        chk("rr_tail0_id", 32'(rsp_id), 0);
        chk("rr_tail0_data", 32'(rsp_data), 12);
        tick();
        chk("rr_tail1_id", 32'(rsp_id), 1);
        chk("rr_tail1_data", 32'(rsp_data), 30);
        tick();
        chk("rr_drained", 32'(rsp_valid), 0);

        // Backpressure: two accepted, then stall with stable outputs.
        rsp_ready = 1'b0;
        set_op(0, 7, 8, 1'b0);
        set_op(1, 9, 10, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("bp_ready0", 32'(req_ready), 1);
        tick();
        chk("bp_ready1", 32'(req_ready), 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_stall_ready", 32'(req_ready), 0);
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_id", 32'(rsp_id), 0);
            chk("bp_hold_data", 32'(rsp_data), 56);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        #1;
        tick();
        chk("bp_drain_valid", 32'(rsp_valid), 1);
        chk("bp_drain_id", 32'(rsp_id), 1);
        chk("bp_drain_data", 32'(rsp_data), 90);
        tick();
        chk("bp_drained", 32'(rsp_valid), 0);

        // Accumulator wraps modulo 2^20 over 17 max products.
        for (int i = 1; i <= 17; i++) begin
            issue(0, 255, 255, 1'b1);
            wait_rsp("wrap", 0, (i * 65025) % 1048576);
        end
        chk("wrap_final", 32'(rsp_data), 56849);

        // Clear coinciding with an accumulate move: clear first, then add.
        issue(0, 255, 255, 1'b1);
        acc_clr = 2'b01;
        tick();
        acc_clr = 2'b00;
        chk("clr_col_valid", 32'(rsp_valid), 1);
        chk("clr_col_data", 32'(rsp_data), 65025);
        tick();
        issue(0, 12, 5, 1'b1);
        wait_rsp("clr_col_after", 0, 65085);

        // Reset with both stages full.
        rsp_ready = 1'b0;
        set_op(0, 2, 3, 1'b1);
        set_op(1, 4, 5, 1'b1);
        req_valid = 2'b11;
        tick();
        tick();
        chk("mid_full", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_data", 32'(rsp_data), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        #3;
        set_op(0, 12, 5, 1'b0);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 1);
        tick();
        req_valid = 2'b00;
        wait_rsp("post_rst_first", 0, 60);
        issue(1, 12, 5, 1'b1);
        wait_rsp("post_rst_acc1", 1, 60);
        issue(0, 12, 5, 1'b1);
        wait_rsp("post_rst_acc0", 0, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
